binary_to_bcd_seq: RTL and testbench
====================================

// Module: binary_to_bcd_seq
// PURPOSE
//  Multi-cycle binary-to-BCD converter (shift-and-add-3 / double dabble) with a start/valid handshake.
//  Successor to the single-value combinational converter. Adds:
//   - generic INPUT_WIDTH and DECIMAL_DIGITS;
//   - a busy/done handshake;
//   - leading-zero digit-enable mask;
//   - overflow flag.
//  Feeds 7-segment display drivers and UART debug formatters.
// PARAMETERS
//  INPUT_WIDTH    7  width of binary input, >=1
//  DECIMAL_DIGITS 2  number of BCD digits produced, >=1
// PORTS
//  i_Clock      in   1                   system clock, all logic on rising edge
//  i_Reset_n    in   1                   asynchronous, active-low reset
//  i_Start      in   1                   request conversion of i_Binary; honoured only when o_Busy=0
//  i_Binary     in   INPUT_WIDTH         unsigned value, sampled on the accepting edge only
//  o_Busy       out  1                   conversion in progress (any state except IDLE)
//  o_DV         out  1                   one-cycle pulse: o_BCD/o_Digit_En/o_Overflow updated
//  o_BCD        out  DECIMAL_DIGITS*4    result, digit d at [4d+3:4d], digit 0 least significant
//  o_Digit_En   out  DECIMAL_DIGITS      1 = display digit (non-leading-zero); bit 0 always 1
//  o_Overflow   out  1                   value > 10^DECIMAL_DIGITS-1; o_BCD then invalid
// BEHAVIOUR
//  Reset (i_Reset_n=0, async assert; deassertion synchronised by the integrator):
//   - all outputs 0, except o_Digit_En = {0..0,1};
//   - FSM goes to IDLE;
//   - working registers cleared.
//  FSM states:
//   IDLE  -> ADD  on i_Start=1. Latch i_Binary into shift reg; clear BCD work reg and overflow.
//   ADD   -> SHIFT. Every work digit >=5 gets +3 (4-bit add, no carry between digits).
//   SHIFT -> ADD if bits remain, else DONE. {work,shift} <<= 1.
//            A 1 leaving MSB of top digit sets sticky overflow.
//   DONE  -> IDLE. No further action in this state.
//  Bit counter: clog2(INPUT_WIDTH+1) bits, counts INPUT_WIDTH SHIFT cycles.
//  Latency:
//   - accepting edge = E0;
//   - last SHIFT occurs on edge E0+2*INPUT_WIDTH; that same edge registers o_DV=1 and
//     updates o_BCD, o_Digit_En, o_Overflow;
//   - o_DV returns to 0 on the next edge (DONE->IDLE);
//   - for INPUT_WIDTH=7: o_DV high in the cycle after edge 14.
//  Throughput: new i_Start may be accepted on the edge where o_Busy=0 (earliest E0+2*INPUT_WIDTH+2).
//  i_Start while o_Busy=1: ignored, not queued.
//  Simultaneous i_Start and DONE->IDLE edge: ignored (FSM is still in DONE).
//  Output hold: o_BCD, o_Digit_En, o_Overflow are held between conversions, change only with o_DV.
//  o_Digit_En[d] = (digit d != 0) OR any higher digit != 0. Bit 0 forced 1 (value 0 shows "0").
//  Overflow result: o_BCD holds the truncated work register; consumers must check o_Overflow.
//  Reset mid-conversion:
//   - aborts immediately; no o_DV;
//   - outputs go to reset values;
//   - next i_Start after release behaves as from power-up.
//  Arithmetic unsigned throughout; digits never exceed 9 unless o_Overflow=1.
// TESTING
//  Default params, i_Start with 10:
//   -> o_DV one cycle after edge 14; o_BCD=8'h10, o_Digit_En=2'b11, o_Overflow=0; o_Busy 0 after DONE.
//  Default params, 99 -> 8'h99, En=2'b11. 5 -> 8'h05, En=2'b01. 0 -> 8'h00, En=2'b01.
//  Default params, 127 -> o_Overflow=1, o_DV still pulses.
//   Same 127 with DECIMAL_DIGITS=3 -> 12'h127, En=3'b111, o_Overflow=0.
//  Start 42; pulse i_Start=1 with i_Binary=77 at edge E0+5:
//   -> exactly one o_DV, o_BCD=8'h42; then 77 accepted after idle -> 8'h77.
//  Start 99; drop i_Reset_n at edge E0+6:
//   -> outputs 0/En=01 immediately, o_DV never pulses;
//   release, start 10 -> 8'h10 with nominal latency.
//  Sweep INPUT_WIDTH=10, DECIMAL_DIGITS=4, all 0..1023 vs reference model:
//   -> BCD, mask, overflow=0 all match; back-to-back starts every 2*W+2 cycles.

Source files
------------

// File: rtl/binary_to_bcd_seq_if.sv
// binary_to_bcd_seq_if: start/result handshake between a requester and the BCD converter.
interface binary_to_bcd_seq_if #(
    parameter int INPUT_WIDTH    = 7,
    parameter int DECIMAL_DIGITS = 2
);
    logic                          i_Start;
    logic [INPUT_WIDTH-1:0]        i_Binary;
    logic                          o_Busy;
    logic                          o_DV;
    logic [DECIMAL_DIGITS*4-1:0]   o_BCD;
    logic [DECIMAL_DIGITS-1:0]     o_Digit_En;
    logic                          o_Overflow;

    modport master (
        output i_Start, i_Binary,
        input  o_Busy, o_DV, o_BCD, o_Digit_En, o_Overflow
    );

    modport slave (
        input  i_Start, i_Binary,
        output o_Busy, o_DV, o_BCD, o_Digit_En, o_Overflow
    );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: multi-cycle double-dabble converter with leading-zero mask and overflow flag.
module binary_to_bcd_seq #(
    parameter int INPUT_WIDTH    = 7,
    parameter int DECIMAL_DIGITS = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    binary_to_bcd_seq_if.slave   bus
);
    localparam int BW = 4 * DECIMAL_DIGITS;
    localparam int CW = $clog2(INPUT_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t                   r_state;
    logic [BW-1:0]            r_work;
    logic [INPUT_WIDTH-1:0]   r_shift;
    logic [CW-1:0]            r_cnt;
    logic                     r_ovf;
    logic [BW-1:0]            w_added;
    logic [BW-1:0]            w_shifted;
    logic [DECIMAL_DIGITS-1:0] w_en;
    logic                     w_ovf;
    logic                     w_last;

    always_comb begin
        w_added = r_work;
        for (int d = 0; d < DECIMAL_DIGITS; d++)
            w_added[4*d +: 4] = (r_work[4*d +: 4] >= 4'd5) ? r_work[4*d +: 4] + 4'd3 : r_work[4*d +: 4];
    end

    assign w_shifted = {r_work[BW-2:0], r_shift[INPUT_WIDTH-1]};
    assign w_ovf     = r_ovf | r_work[BW-1];
    assign w_last    = (r_cnt == CW'(INPUT_WIDTH - 1));

    // A digit is shown once it or any more significant digit is non-zero.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        w_en = '0;
        for (int d = DECIMAL_DIGITS - 1; d >= 0; d--) begin
            acc     = acc | (|w_shifted[4*d +: 4]);
            w_en[d] = acc;
        end
        w_en[0] = 1'b1;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state        <= IDLE;
            r_work         <= '0;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            bus.o_Busy     <= 1'b0;
            bus.o_DV       <= 1'b0;
            bus.o_BCD      <= '0;
            bus.o_Digit_En <= DECIMAL_DIGITS'(1);
            bus.o_Overflow <= 1'b0;
        end else begin
            bus.o_DV <= 1'b0;
            case (r_state)
                IDLE: if (bus.i_Start) begin
                    r_shift    <= bus.i_Binary;
                    r_work     <= '0;
                    r_ovf      <= 1'b0;
                    r_cnt      <= '0;
                    bus.o_Busy <= 1'b1;
                    r_state    <= ADD;
                end
                ADD: begin
                    r_work  <= w_added;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_work  <= w_shifted;
                    r_shift <= r_shift << 1;
                    r_ovf   <= w_ovf;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_last ? DONE : ADD;
                    if (w_last) begin
                        bus.o_DV       <= 1'b1;
                        bus.o_BCD      <= w_shifted;
                        bus.o_Digit_En <= w_en;
                        bus.o_Overflow <= w_ovf;
                    end
                end
                DONE: begin
                    bus.o_Busy <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: three converter configurations driven in lockstep and scored against
// an arithmetic decimal model.
module tb_binary_to_bcd_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st = 1'b0;
    logic [9:0] bin = '0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         qv[3][$];
    int         qc[3][$];
    int         dvcnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    binary_to_bcd_seq_if #(7, 2)  b0 ();
    binary_to_bcd_seq_if #(7, 3)  b1 ();
    binary_to_bcd_seq_if #(10, 4) b2 ();

    binary_to_bcd_seq #(.INPUT_WIDTH(7),  .DECIMAL_DIGITS(2)) u0 (.i_Clock(clk), .i_Reset_n(rst_n), .bus(b0));
    binary_to_bcd_seq #(.INPUT_WIDTH(7),  .DECIMAL_DIGITS(3)) u1 (.i_Clock(clk), .i_Reset_n(rst_n), .bus(b1));
    binary_to_bcd_seq #(.INPUT_WIDTH(10), .DECIMAL_DIGITS(4)) u2 (.i_Clock(clk), .i_Reset_n(rst_n), .bus(b2));

    assign b0.i_Start = st;
    assign b1.i_Start = st;
    assign b2.i_Start = st;
    assign b0.i_Binary = bin[6:0];
    assign b1.i_Binary = bin[6:0];
    assign b2.i_Binary = bin;

    logic [2:0]  dv, busy, ovf;
    logic [15:0] bcd [3];
    logic [3:0]  en [3];
    logic [9:0]  bv [3];
    assign dv   = {b2.o_DV, b1.o_DV, b0.o_DV};
    assign busy = {b2.o_Busy, b1.o_Busy, b0.o_Busy};
    assign ovf  = {b2.o_Overflow, b1.o_Overflow, b0.o_Overflow};
    assign bcd[0] = 16'(b0.o_BCD);
    assign bcd[1] = 16'(b1.o_BCD);
    assign bcd[2] = b2.o_BCD;
    assign en[0] = 4'(b0.o_Digit_En);
    assign en[1] = 4'(b1.o_Digit_En);
    assign en[2] = b2.o_Digit_En;
    assign bv[0] = 10'(b0.i_Binary);
    assign bv[1] = 10'(b1.i_Binary);
    assign bv[2] = b2.i_Binary;

    function automatic int wid(int k);
        return (k == 2) ? 10 : 7;
    endfunction

    function automatic int dig(int k);
        return k + 2;
    endfunction

    function automatic int m_bcd(int v, int d);
        int r = 0, p = 1;
        for (int i = 0; i < d; i++) begin
            r += ((v / p) % 10) << (4 * i);
            p *= 10;
        end
        return r;
    endfunction

    function automatic int m_en(int v, int d);
        int r = 1, p = 10;
        for (int i = 1; i < d; i++) begin
            if (v >= p) r |= 1 << i;
            p *= 10;
        end
        return r;
    endfunction

    function automatic int m_ovf(int v, int d);
        int p = 1;
        for (int i = 0; i < d; i++) p *= 10;
        return int'(v >= p);
    endfunction

    function automatic void chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    endfunction

    // Record every value a converter takes, with the edge number that accepted it.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++)
            if (rst_n && st && !busy[k]) begin
                qv[k].push_back(int'(bv[k]));
                qc[k].push_back(cyc);
            end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                qv[k].delete();
                qc[k].delete();
            end
        end else begin
            for (int k = 0; k < 3; k++)
                if (dv[k]) begin
                    dvcnt[k]++;
                    if (qv[k].size() == 0) chk("dv_expected", 0, 1);
                    else begin
                        int v, c;
                        v = qv[k].pop_front();
                        c = qc[k].pop_front();
                        chk("latency", cyc - c, 2 * wid(k));
                        chk("overflow", int'(ovf[k]), m_ovf(v, dig(k)));
                        if (m_ovf(v, dig(k)) == 0) begin
                            chk("bcd", int'(bcd[k]), m_bcd(v, dig(k)));
                            chk("digit_en", int'(en[k]), m_en(v, dig(k)));
                        end
                    end
                end
        end
    end

    task automatic start(input int v);
        @(negedge clk);
        st  = 1'b1;
        bin = 10'(v);
        @(negedge clk);
        st  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (busy == 3'b000) && (qv[0].size() + qv[1].size() + qv[2].size() == 0);
        end
        chk("done_in_time", int'(ok), 1);
    endtask

    task automatic chk_reset_vals();
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", int'(busy[k]), 0);
            chk("rst_dv", int'(dv[k]), 0);
            chk("rst_bcd", int'(bcd[k]), 0);
            chk("rst_en", int'(en[k]), 1);
            chk("rst_ovf", int'(ovf[k]), 0);
        end
    endtask

    typedef struct {
        int v;
        int bcd2;
        int en2;
        int ovf2;
        int bcd3;
        int en3;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n0, n2;
        tbl[0] = '{10,  'h10, 'b11, 0, 'h010, 'b011};
        tbl[1] = '{99,  'h99, 'b11, 0, 'h099, 'b011};
        tbl[2] = '{5,   'h05, 'b01, 0, 'h005, 'b001};
        tbl[3] = '{0,   'h00, 'b01, 0, 'h000, 'b001};
        tbl[4] = '{127, 'h00, 'b00, 1, 'h127, 'b111};
        #23;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n0 = dvcnt[0];
            start(tbl[i].v);
            wait_idle(60);
            chk("tbl_dv_once", dvcnt[0] - n0, 1);
            chk("tbl_ovf2", int'(b0.o_Overflow), tbl[i].ovf2);
            if (tbl[i].ovf2 == 0) begin
                chk("tbl_bcd2", int'(b0.o_BCD), tbl[i].bcd2);
                chk("tbl_en2", int'(b0.o_Digit_En), tbl[i].en2);
            end
            chk("tbl_bcd3", int'(b1.o_BCD), tbl[i].bcd3);
            chk("tbl_en3", int'(b1.o_Digit_En), tbl[i].en3);
            chk("tbl_ovf3", int'(b1.o_Overflow), 0);
        end
        // A start arriving mid-conversion must be dropped, not queued.
        n0 = dvcnt[0];
        start(42);
        repeat (4) @(negedge clk);
        st  = 1'b1;
        bin = 10'd77;
        @(negedge clk);
        st  = 1'b0;
        wait_idle(60);
        chk("busy_start_dv", dvcnt[0] - n0, 1);
        chk("busy_start_bcd", int'(b0.o_BCD), 'h42);
        start(77);
        wait_idle(60);
        repeat (5) @(negedge clk);
        chk("hold_bcd", int'(b0.o_BCD), 'h77);
        chk("hold_dv", int'(b0.o_DV), 0);
        // Reset mid-conversion.
        n0 = dvcnt[0];
        start(99);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_dv", dvcnt[0] - n0, 0);
        start(10);
        wait_idle(60);
        chk("after_abort_bcd", int'(b0.o_BCD), 'h10);
        chk("after_abort_en", int'(b0.o_Digit_En), 'b11);
        for (int i = 0; i < 40; i++) begin
            start(int'($urandom_range(0, 1023)));
            wait_idle(60);
        end
        // Back-to-back sweep at the wide converter's minimum start spacing.
        n2 = dvcnt[2];
        for (int v = 0; v < 1024; v++) begin
            start(v);
            repeat (20) @(negedge clk);
        end
        wait_idle(60);
        chk("sweep_dv_count", dvcnt[2] - n2, 1024);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
